// File: rtl/shift_reg_pkg.sv
// Shared definitions for shift_register_nd: mode encodings and counter sizing.
`timescale 1ns/1ps
package shift_reg_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHL  = 2'b01;
  localparam logic [1:0] MODE_SHR  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // Bits needed to hold the values 0..width inclusive.
  function automatic int calc_cnt_w(input int width);
    int w;
    w = 32'sd1;
    while ((32'sd1 << w) < (width + 32'sd1)) begin
      w = w + 32'sd1;
    end
    return w;
  endfunction

endpackage

// File: rtl/shift_bit_counter.sv
// Shift counter for shift_register_nd: counts shifts and pulses WordValid
// on the edge that completes a WIDTH-bit word.
`timescale 1ns/1ps
module shift_bit_counter
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CNT_W = calc_cnt_w(WIDTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             shift_en,
  input  logic             clear,
  output logic [CNT_W-1:0] BitCnt,
  output logic             WordValid
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             word_valid_d, word_valid_q;

  // Next count and completion pulse; the pulse is only ever one shift wide.
  always_comb begin
    cnt_d        = cnt_q;
    word_valid_d = 1'b0;
    if (clear) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (shift_en) begin
      if (cnt_q == LAST_CNT) begin
        cnt_d        = {CNT_W{1'b0}};
        word_valid_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter state with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q        <= {CNT_W{1'b0}};
      word_valid_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      word_valid_q <= word_valid_d;
    end
  end

  assign BitCnt    = cnt_q;
  assign WordValid = word_valid_q;

endmodule

// File: rtl/shift_register_nd.sv
// Universal shift register (hold / shift left / shift right / load) with word counter.
// Optional rotate feedback is enabled by defining SHIFT_REG_ROTATE_EN.
`timescale 1ns/1ps
module shift_register_nd
  import shift_reg_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
  localparam int              CNT_W       = calc_cnt_w(WIDTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [1:0]       Mode,
  input  logic             SinL,
  input  logic             SinR,
  input  logic [WIDTH-1:0] Din,
  input  logic             Rotate,
  output logic [WIDTH-1:0] Q,
  output logic             SoutL,
  output logic             SoutR,
  output logic [CNT_W-1:0] BitCnt,
  output logic             WordValid
);

  logic [WIDTH-1:0] q_d, q_q;
  logic             fill_l_s, fill_r_s;
  logic             shift_s, clear_s;

`ifdef SHIFT_REG_ROTATE_EN
  // Rotate feeds the departing bit back instead of the serial input.
  always_comb begin
    if (Rotate) begin
      fill_l_s = q_q[WIDTH-1];
      fill_r_s = q_q[0];
    end else begin
      fill_l_s = SinL;
      fill_r_s = SinR;
    end
  end
`else
  logic rotate_unused_s;
  assign rotate_unused_s = Rotate;
  assign fill_l_s        = SinL;
  assign fill_r_s        = SinR;
`endif

  // Next register value per mode.
  always_comb begin
    q_d = q_q;
    case (Mode)
      MODE_HOLD: q_d = q_q;
      MODE_SHL:  q_d = {q_q[WIDTH-2:0], fill_l_s};
      MODE_SHR:  q_d = {fill_r_s, q_q[WIDTH-1:1]};
      MODE_LOAD: q_d = Din;
      default:   q_d = q_q;
    endcase
  end

  // Data register with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      q_q <= RESET_VALUE;
    end else begin
      q_q <= q_d;
    end
  end

  assign shift_s = (Mode == MODE_SHL) || (Mode == MODE_SHR);
  assign clear_s = (Mode == MODE_LOAD);

  shift_bit_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .Clk       (Clk),
    .Reset     (Reset),
    .shift_en  (shift_s),
    .clear     (clear_s),
    .BitCnt    (BitCnt),
    .WordValid (WordValid)
  );

  assign Q     = q_q;
  assign SoutL = q_q[WIDTH-1];
  assign SoutR = q_q[0];

endmodule

// File: tb/tb_shift_register_nd.sv
// Self-checking bench for shift_register_nd (WIDTH=8, RESET_VALUE=8'hA5) against a behavioural model.
`timescale 1ns/1ps
module tb_shift_register_nd;

  localparam int         W  = 8;
  localparam logic [7:0] RV = 8'hA5;
`ifdef SHIFT_REG_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [1:0] Mode = 2'b11;
  logic       SinL = 1'b0, SinR = 1'b0, Rotate = 1'b0;
  logic [7:0] Din = 8'h00;
  logic [7:0] Q;
  logic       SoutL, SoutR, WordValid;
  logic [3:0] BitCnt;

  int checks = 0;
  int fails  = 0;

  // model state
  logic [7:0] m_q   = 8'h00;
  int         m_cnt = 0;
  logic       m_wv  = 1'b0;

  shift_register_nd #(.WIDTH(W), .RESET_VALUE(RV)) dut (
    .Clk(Clk), .Reset(Reset), .Mode(Mode), .SinL(SinL), .SinR(SinR),
    .Din(Din), .Rotate(Rotate), .Q(Q), .SoutL(SoutL), .SoutR(SoutR),
    .BitCnt(BitCnt), .WordValid(WordValid)
  );

  always #5 Clk = ~Clk;

  wire [14:0] obs = {Q, SoutL, SoutR, BitCnt, WordValid};

  function automatic logic [14:0] exp_vec();
    return {m_q, m_q[7], m_q[0], 4'(m_cnt), m_wv};
  endfunction

  task automatic model_step(input logic rst, input logic [1:0] mode, input logic sl,
                            input logic sr, input logic [7:0] din, input logic rot);
    logic in_bit;
    if (rst) begin
      m_q = RV; m_cnt = 0; m_wv = 1'b0;
    end else if (mode == 2'd3) begin
      m_q = din; m_cnt = 0; m_wv = 1'b0;
    end else if (mode == 2'd0) begin
      m_wv = 1'b0;
    end else begin
      if (mode == 2'd1) begin
        in_bit = (ROT_EN && rot) ? m_q[7] : sl;
        m_q = (m_q << 1) | 8'(in_bit);
      end else begin
        in_bit = (ROT_EN && rot) ? m_q[0] : sr;
        m_q = (m_q >> 1) | (8'(in_bit) << 7);
      end
      m_cnt = m_cnt + 1;
      if (m_cnt == W) begin
        m_cnt = 0; m_wv = 1'b1;
      end else begin
        m_wv = 1'b0;
      end
    end
  endtask

  task automatic drive(input logic rst, input logic [1:0] mode, input logic sl,
                       input logic sr, input logic [7:0] din, input logic rot);
    Reset = rst; Mode = mode; SinL = sl; SinR = sr; Din = din; Rotate = rot;
    @(posedge Clk);
    #1;
    model_step(rst, mode, sl, sr, din, rot);
  endtask

  task automatic test_reset();
    drive(1'b1, 2'b11, 1'b1, 1'b1, 8'hFF, 1'b0);
    checks++;
    if (Q !== 8'hA5 || BitCnt !== 4'd0 || WordValid !== 1'b0) begin
      fails++;
      $display("FAIL reset: Q=%h cnt=%0d wv=%b, expected Q=a5 cnt=0 wv=0", Q, BitCnt, WordValid);
    end
  endtask

  task automatic test_shift_left();
    logic [7:0] bits = 8'b1011_0010;
    drive(1'b0, 2'b11, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 2'b01, bits[7-i], 1'b0, 8'h00, 1'b0);
      checks++;
      if (obs !== exp_vec()) begin
        fails++;
        $display("FAIL shl_step%0d: got %h expected %h", i, obs, exp_vec());
      end
      if (i < 7) begin
        checks++;
        if (BitCnt !== 4'(i + 1) || WordValid !== 1'b0) begin
          fails++;
          $display("FAIL shl_cnt%0d: cnt=%0d wv=%b expected cnt=%0d wv=0", i, BitCnt, WordValid, i + 1);
        end
      end
    end
    checks++;
    if (Q !== 8'hB2 || BitCnt !== 4'd0 || WordValid !== 1'b1) begin
      fails++;
      $display("FAIL shl_word: Q=%h cnt=%0d wv=%b expected Q=b2 cnt=0 wv=1", Q, BitCnt, WordValid);
    end
    drive(1'b0, 2'b00, 1'b1, 1'b1, 8'hFF, 1'b0);
    checks++;
    if (WordValid !== 1'b0 || Q !== 8'hB2) begin
      fails++;
      $display("FAIL shl_after: Q=%h wv=%b expected Q=b2 wv=0", Q, WordValid);
    end
  endtask

  task automatic test_shift_right_load();
    drive(1'b0, 2'b11, 1'b0, 1'b0, 8'h81, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 2'b10, 1'b1, 1'b0, 8'hFF, 1'b0);
    checks++;
    if (Q !== 8'h10 || BitCnt !== 4'd3 || SoutR !== 1'b0 || obs !== exp_vec()) begin
      fails++;
      $display("FAIL shr: Q=%h cnt=%0d soutr=%b expected Q=10 cnt=3 soutr=0", Q, BitCnt, SoutR);
    end
    drive(1'b0, 2'b11, 1'b0, 1'b0, 8'h5C, 1'b0);
    checks++;
    if (Q !== 8'h5C || BitCnt !== 4'd0 || WordValid !== 1'b0) begin
      fails++;
      $display("FAIL load_clear: Q=%h cnt=%0d wv=%b expected Q=5c cnt=0 wv=0", Q, BitCnt, WordValid);
    end
  endtask

  task automatic test_hold_mixed();
    int pulses = 0;
    int pulse_step = -1;
    logic [7:0] q_before;
    logic [3:0] c_before;
    drive(1'b0, 2'b11, 1'b0, 1'b0, 8'h3C, 1'b0);
    for (int s = 0; s < 10; s++) begin
      q_before = Q; c_before = BitCnt;
      if (s < 5)      drive(1'b0, 2'b01, 1'($urandom_range(1)), 1'b0, 8'hFF, 1'b0);
      else if (s < 7) drive(1'b0, 2'b00, 1'b1, 1'b1, 8'hFF, 1'b0);
      else            drive(1'b0, 2'b10, 1'b0, 1'($urandom_range(1)), 8'hFF, 1'b0);
      if (WordValid === 1'b1) begin pulses++; pulse_step = s; end
      checks++;
      if (obs !== exp_vec()) begin
        fails++;
        $display("FAIL mixed_step%0d: got %h expected %h", s, obs, exp_vec());
      end
      if (s == 5 || s == 6) begin
        checks++;
        if (Q !== q_before || BitCnt !== c_before) begin
          fails++;
          $display("FAIL hold%0d: Q=%h cnt=%0d expected Q=%h cnt=%0d", s, Q, BitCnt, q_before, c_before);
        end
      end
    end
    checks++;
    if (pulses != 1 || pulse_step != 9) begin
      fails++;
      $display("FAIL mixed_wv: pulses=%0d at step %0d expected 1 at step 9", pulses, pulse_step);
    end
  endtask

  task automatic test_rotate();
    drive(1'b0, 2'b11, 1'b0, 1'b0, 8'h81, 1'b0);
    drive(1'b0, 2'b01, 1'b0, 1'b0, 8'h00, 1'b1);
    checks++;
    if (Q !== (ROT_EN ? 8'h03 : 8'h02) || obs !== exp_vec()) begin
      fails++;
      $display("FAIL rotate_l: Q=%h expected %h", Q, ROT_EN ? 8'h03 : 8'h02);
    end
    drive(1'b0, 2'b10, 1'b0, 1'b0, 8'h00, 1'b1);
    checks++;
    if (obs !== exp_vec()) begin
      fails++;
      $display("FAIL rotate_r: got %h expected %h", obs, exp_vec());
    end
  endtask

  task automatic test_reset_midword();
    int pulses = 0;
    drive(1'b0, 2'b11, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 2'b01, 1'b1, 1'b0, 8'h00, 1'b0);
    drive(1'b1, 2'b01, 1'b1, 1'b0, 8'h00, 1'b0);
    checks++;
    if (Q !== 8'hA5 || BitCnt !== 4'd0 || WordValid !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: Q=%h cnt=%0d wv=%b expected Q=a5 cnt=0 wv=0", Q, BitCnt, WordValid);
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 2'b01, 1'($urandom_range(1)), 1'b0, 8'h00, 1'b0);
      if (WordValid === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1 || WordValid !== 1'b1 || obs !== exp_vec()) begin
      fails++;
      $display("FAIL reset_mid_word: pulses=%0d last wv=%b expected 1 pulse on 8th shift", pulses, WordValid);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(31) == 0), 2'($urandom_range(3)), 1'($urandom_range(1)),
            1'($urandom_range(1)), 8'($urandom), 1'($urandom_range(1)));
      checks++;
      if (obs !== exp_vec()) begin
        fails++;
        $display("FAIL random%0d: got %h expected %h", i, obs, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_shift_left();
    test_shift_right_load();
    test_hold_mixed();
    test_rotate();
    test_reset_midword();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/shift_register_nd.md
Name: shift_register_nd

Overview:
- Parametrised universal shift register; successor to the fixed 8-bit serial-in shift register.
- Adds configurable width, four operating modes (hold, shift left, shift right, parallel load) and serial outputs at both ends.
- Adds a shift counter that flags each completed word, so the block can act as a serial-to-parallel deserializer.
- Sits between serial pin logic and parallel datapath logic in lab designs; one instance per serial channel.

Parameters:
- WIDTH, 8, register width in bits; legal range 2..64.
- RESET_VALUE, 0, value loaded into Q on reset (WIDTH bits).
- CNT_W, $clog2(WIDTH+1), width of the shift counter; derived, not overridden.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- Mode  input  2  00 hold, 01 shift left, 10 shift right, 11 parallel load.
- SinL  input  1  serial input entering bit 0 on a left shift.
- SinR  input  1  serial input entering bit WIDTH-1 on a right shift.
- Din  input  WIDTH  parallel load data.
- Rotate  input  1  rotate select; only effective with SHIFT_REG_ROTATE_EN.
- Q  output  WIDTH  register contents.
- SoutL  output  1  equals Q[WIDTH-1]; combinational from the register.
- SoutR  output  1  equals Q[0]; combinational from the register.
- BitCnt  output  CNT_W  number of shifts since the last load, reset or word completion.
- WordValid  output  1  one-cycle pulse marking that Q holds a complete shifted word.

Behaviour:
- Reset is sampled only on the rising Clk edge and has priority over everything else.
  - On reset: Q=RESET_VALUE, BitCnt=0, WordValid=0.
  - Reset asserted mid-word discards the partial count and takes effect at the next edge.
- Register update, all at the rising edge:
  - Mode 00: Q holds; BitCnt holds; WordValid=0.
  - Mode 01 (shift left): Q <= {Q[WIDTH-2:0], SinL}.
  - Mode 10 (shift right): Q <= {SinR, Q[WIDTH-1:1]}.
  - Mode 11 (parallel load): Q <= Din; BitCnt <= 0; WordValid <= 0.
- Counter, on each shift (Mode 01 or 10):
  - If BitCnt == WIDTH-1: BitCnt <= 0 and WordValid <= 1 on the same edge that shifts in the last bit. WordValid is therefore high during the cycle in which Q holds the complete word.
  - Otherwise: BitCnt <= BitCnt+1 and WordValid <= 0.
- WordValid is registered and is never high for two consecutive cycles unless two consecutive words complete.
  - For WIDTH=2 back-to-back words are possible, with WordValid high every second shift.
- Direction changes mid-word (01 then 10) are legal. The count continues to accumulate regardless of direction.
- SoutL and SoutR reflect the current Q, i.e. the bit that is shifted out on the next edge.
- No internal clock gating. Din, SinL and SinR are ignored except in their respective modes.

Optional Feature:
- Macro: SHIFT_REG_ROTATE_EN.
- Defined: when Rotate=1 in a shift mode, the bit that leaves the register is fed back in place of the serial input.
  - Left rotate: Q <= {Q[WIDTH-2:0], Q[WIDTH-1]}.
  - Right rotate: Q <= {Q[0], Q[WIDTH-1:1]}.
  - The counter and WordValid behave exactly as for a normal shift.
- Undefined: the Rotate port is still present but ignored, and the shift modes always use SinL/SinR.

Decomposition:
- Shared package shift_reg_pkg holds the mode encodings MODE_HOLD=2'b00, MODE_SHL=2'b01, MODE_SHR=2'b10, MODE_LOAD=2'b11.
- The package also holds a function computing CNT_W from WIDTH.
- One sub-module is natural: shift_bit_counter.
  - Inputs: Clk, Reset, shift enable, clear.
  - Outputs: BitCnt, WordValid.
  - Parameter: WIDTH.
- The data path stays in the top module.

Test Plan:
- WIDTH=8, RESET_VALUE=8'hA5; assert Reset for 1 edge with Mode=11 and Din=8'hFF -> Q=8'hA5, BitCnt=0, WordValid=0 (reset wins over load).
- Mode=01 with SinL driven 1,0,1,1,0,0,1,0 over 8 edges from Q=0 -> Q=8'hB2 after the 8th edge. WordValid is high only in that cycle and BitCnt=0. BitCnt steps 1..7 on the prior edges.
- Load Din=8'h81, then Mode=10 with SinR=0 for 3 edges -> Q=8'h10, BitCnt=3, SoutR=0. A following Mode=11 clears BitCnt to 0 with no WordValid.
- 5 left shifts, 2 cycles of Mode=00, then 3 right shifts -> WordValid fires on the 8th shift edge only. Q and BitCnt are unchanged during hold.
- With SHIFT_REG_ROTATE_EN: load 8'h81, Rotate=1, Mode=01 for 1 edge -> Q=8'h03. Without the macro, the same stimulus with SinL=0 gives Q=8'h02.
- Reset asserted after 4 of 8 shifts -> BitCnt=0 and Q=RESET_VALUE. The next full 8 shifts produce exactly one WordValid pulse.
